frame_streamer: RTL

//  Pixel-stream transmitter feeding the motion_detector input (pixel_valid/pixel_data).

---
 rtl/snn_stream_pkg.sv | 31 +++
 rtl/frame_streamer_if.sv | 26 ++
 rtl/frame_buffer_ram.sv | 27 ++
 rtl/frame_streamer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/snn_stream_pkg.sv
// Shared types and default geometry for the SNN pixel-stream path.
// Holds the streamer state encoding and the default frame dimensions.
package snn_stream_pkg;

   localparam int DEF_IMG_WIDTH    = 16;
   localparam int DEF_IMG_HEIGHT   = 16;
   localparam int DEF_PIXEL_WIDTH  = 8;
   localparam int DEF_GAP_CYCLES   = 4;
   localparam int DEF_DONE_TIMEOUT = 64;

   localparam int FRAME_SIZE = DEF_IMG_WIDTH * DEF_IMG_HEIGHT;
   localparam int PIX_IDX_W  = $clog2(FRAME_SIZE);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAKE,
      ST_STREAM,
      ST_WAIT_DONE,
      ST_GAP
   } state_t;

   typedef struct packed {
      logic repeat_en;
      logic pattern_en;
   } frame_stream_cfg_t;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/frame_streamer_if.sv
// Host write port plus detector-facing pixel stream of the frame streamer.
// master = the streamer, slave = the host/detector side.
interface frame_streamer_if
   import snn_stream_pkg::*;
#(
   parameter int PW = DEF_PIXEL_WIDTH
) ();

   logic          wr_valid;
   logic [PW-1:0] wr_data;
   logic          wr_ready;
   logic          frame_done_in;
   logic          pixel_valid;
   logic [PW-1:0] pixel_data;

   modport master (
      input  wr_valid, wr_data, frame_done_in,
      output wr_ready, pixel_valid, pixel_data
   );

   modport slave (
      output wr_valid, wr_data, frame_done_in,
      input  wr_ready, pixel_valid, pixel_data
   );

endinterface

// File: rtl/frame_buffer_ram.sv
// One-frame pixel store: single write port, single read port, registered read data.
// Read data appears one clock after the address is presented.
module frame_buffer_ram
   import snn_stream_pkg::*;
#(
   parameter int DEPTH = FRAME_SIZE,
   parameter int AW    = PIX_IDX_W,
   parameter int DW    = DEF_PIXEL_WIDTH
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [DEPTH];

   // NOTE: no reset on the array or its read register, so it maps onto block RAM;
   // validity is tracked by buf_full in the controller, not by the contents.
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      o_rdata <= r_mem[i_raddr];
   end

endmodule

// File: rtl/frame_streamer.sv
// Buffers one host-loaded frame and replays it as wake beat + contiguous raster burst.
// Optional moving-bar test pattern is built only when FRAME_STREAMER_PATTERN_EN is defined.
module frame_streamer
   import snn_stream_pkg::*;
#(
   parameter int IMG_WIDTH    = DEF_IMG_WIDTH,
   parameter int IMG_HEIGHT   = DEF_IMG_HEIGHT,
   parameter int PIXEL_WIDTH  = DEF_PIXEL_WIDTH,
   parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
   parameter int DONE_TIMEOUT = DEF_DONE_TIMEOUT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   frame_streamer_if.master      bus,
   input  logic                  start,
   input  logic                  repeat_en,
   input  logic                  pattern_en,
   output logic                  busy,
   output logic [7:0]            frames_sent,
   output logic                  err_timeout
);

   localparam int FRAME_N = IMG_WIDTH * IMG_HEIGHT;
   localparam int IDX_W   = $clog2(FRAME_N);
   localparam int CNT_W   = $clog2(max2(DONE_TIMEOUT, GAP_CYCLES)) + 1;

   state_t                 r_state;
   logic [IDX_W-1:0]       r_wr_ptr;
   logic [IDX_W-1:0]       r_rd_ptr;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_buf_full;
   logic                   r_busy;
   logic                   r_pixel_valid;
   logic [PIXEL_WIDTH-1:0] r_pixel_data;
   logic                   r_ram_sel;
   logic                   r_pat_sel;
   logic [7:0]             r_frames_sent;
   logic                   r_err;

   frame_stream_cfg_t      w_cfg;
   logic                   w_wr_ready;
   logic                   w_wr_fire;
   logic                   w_frame_done;
   logic                   w_pattern_req;
   logic [IDX_W-1:0]       w_next_idx;
   logic [PIXEL_WIDTH-1:0] w_ram_rdata;
   logic [PIXEL_WIDTH-1:0] w_pattern_pix;

   assign w_cfg        = '{repeat_en: repeat_en, pattern_en: pattern_en};
   assign w_wr_ready   = !r_buf_full && (r_state == ST_IDLE);
   assign w_wr_fire    = bus.wr_valid && w_wr_ready;
   assign w_frame_done = (r_state == ST_WAIT_DONE) && bus.frame_done_in;

   // Index of the beat that follows the current cycle: feeds the RAM read
   // address and the pattern generator so both line up with the next beat.
   assign w_next_idx = (r_state == ST_WAKE) ? '0 : r_rd_ptr + IDX_W'(1);

`ifdef FRAME_STREAMER_PATTERN_EN
   localparam int COL_W = $clog2(IMG_WIDTH);

   logic [COL_W-1:0] r_bar_pos;

   assign w_pattern_req = w_cfg.pattern_en;
   assign w_pattern_pix = (w_next_idx[COL_W-1:0] == r_bar_pos) ? '1 : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        r_bar_pos <= '0;
      else if (w_frame_done && r_pat_sel) r_bar_pos <= r_bar_pos + COL_W'(1);
   end
`else
   logic w_unused_pattern_en;

   assign w_pattern_req       = 1'b0;
   assign w_pattern_pix       = '0;
   assign w_unused_pattern_en = w_cfg.pattern_en;
`endif

   frame_buffer_ram #(
      .DEPTH (FRAME_N),
      .AW    (IDX_W),
      .DW    (PIXEL_WIDTH)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_wr_fire),
      .i_waddr (r_wr_ptr),
      .i_wdata (bus.wr_data),
      .i_raddr (w_next_idx),
      .o_rdata (w_ram_rdata)
   );

   // NOTE: all state is written with <= so every branch sees the values from
   // before this edge, regardless of statement order inside the block.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_cnt         <= '0;
         r_buf_full    <= 1'b0;
         r_busy        <= 1'b0;
         r_pixel_valid <= 1'b0;
         r_pixel_data  <= '0;
         r_ram_sel     <= 1'b0;
         r_pat_sel     <= 1'b0;
         r_frames_sent <= '0;
         r_err         <= 1'b0;
      end else begin
         if (w_wr_fire) begin
            r_wr_ptr <= r_wr_ptr + IDX_W'(1);
            if (r_wr_ptr == IDX_W'(FRAME_N - 1)) r_buf_full <= 1'b1;
         end

         unique case (r_state)
            ST_IDLE: begin
               if (start && (r_buf_full || w_pattern_req)) begin
                  r_state       <= ST_WAKE;
                  r_busy        <= 1'b1;
                  r_pixel_valid <= 1'b1;
                  r_pixel_data  <= '0;
                  r_pat_sel     <= w_pattern_req;
               end
            end

            ST_WAKE: begin
               r_state      <= ST_STREAM;
               r_rd_ptr     <= '0;
               r_ram_sel    <= !r_pat_sel;
               r_pixel_data <= r_pat_sel ? w_pattern_pix : '0;
            end

            ST_STREAM: begin
               if (r_rd_ptr == IDX_W'(FRAME_N - 1)) begin
                  r_state       <= ST_WAIT_DONE;
                  r_pixel_valid <= 1'b0;
                  r_ram_sel     <= 1'b0;
                  r_pixel_data  <= '0;
                  r_cnt         <= '0;
               end else begin
                  r_rd_ptr     <= w_next_idx;
                  r_pixel_data <= r_pat_sel ? w_pattern_pix : '0;
               end
            end

            ST_WAIT_DONE: begin
               // A done pulse on the final timeout cycle still counts as done.
               if (bus.frame_done_in || (r_cnt == CNT_W'(DONE_TIMEOUT - 1))) begin
                  r_state <= ST_GAP;
                  r_cnt   <= '0;
                  if (bus.frame_done_in) r_frames_sent <= r_frames_sent + 8'd1;
                  else                   r_err         <= 1'b1;
                  if (!w_cfg.repeat_en && !r_pat_sel) r_buf_full <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end

            ST_GAP: begin
               if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.wr_ready    = w_wr_ready;
   assign bus.pixel_valid = r_pixel_valid;
   assign bus.pixel_data  = r_ram_sel ? w_ram_rdata : r_pixel_data;
   assign busy            = r_busy;
   assign frames_sent     = r_frames_sent;
   assign err_timeout     = r_err;

endmodule
